// File: rtl/cpu_mem_bus_arbiter.sv
// Memory bus arbiter shared by NUM_REQ cache ports.
// The bus is offered to one cache at a time in round-robin order. A read or write pulse from
// the offered cache is captured and forwarded to memory as a one-cycle pulse. The bus is then
// held until memory returns a response with a matching address. That response goes back only
// to the owning cache.
//
// Ports:
//   clock, reset                      rising-edge clock, async active-low reset
//   req_read/req_write                per-requester request pulses
//   req_addr/req_data                 flat per-requester address / write line
//   bus_available                     one-hot offer to the current requester
//   resp_valid/resp_addr/resp_data    one-hot response strobe plus shared response payload
//   mem_read/mem_write                one-cycle request pulses to memory
//   mem_addr/mem_data                 latched request address / write line
//   mem_resp_valid/addr/data          memory response
//   busy                              transaction outstanding
//   spurious                          pulse for each dropped memory response
module cpu_mem_bus_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LINE_WIDTH   = 128,
  parameter int unsigned GRANT_WINDOW = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LINE_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            bus_available,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [ADDR_WIDTH-1:0]         resp_addr,
  output logic [LINE_WIDTH-1:0]         resp_data,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [LINE_WIDTH-1:0]         mem_data,
  input  logic                          mem_resp_valid,
  input  logic [ADDR_WIDTH-1:0]         mem_resp_addr,
  input  logic [LINE_WIDTH-1:0]         mem_resp_data,
  output logic                          busy,
  output logic                          spurious
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (GRANT_WINDOW > 1) ? $clog2(GRANT_WINDOW) : 1;

  typedef enum logic [1:0] {StOffer, StIssue, StWait} state_e;

  state_e                  state_q, state_d;
  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic [PtrW-1:0]         owner_q, owner_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      bus_available_q, bus_available_d;
  logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
  logic [ADDR_WIDTH-1:0]   resp_addr_q, resp_addr_d;
  logic [LINE_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic                    busy_q, busy_d;
  logic                    spurious_q, spurious_d;

  logic                    offered;
  logic                    req_hit;
  logic                    resp_match;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PtrW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    next_ptr = (p == PtrW'(NUM_REQ - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Offer is zero for one cycle after reset release; no capture or counting in that cycle.
  assign offered    = bus_available_q[ptr_q];
  assign req_hit    = offered & (req_read[ptr_q] | req_write[ptr_q]);
  assign resp_match = mem_resp_valid & (mem_resp_addr == mem_addr_q);

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    owner_d         = owner_q;
    cnt_d           = cnt_q;
    bus_available_d = bus_available_q;
    resp_valid_d    = '0;
    resp_addr_d     = resp_addr_q;
    resp_data_d     = resp_data_q;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_data_d      = mem_data_q;
    busy_d          = busy_q;
    spurious_d      = 1'b0;

    case (state_q)
      StOffer: begin
        spurious_d = mem_resp_valid;
        if (!offered) begin
          bus_available_d = onehot(ptr_q);
        end else if (req_hit) begin
          owner_d         = ptr_q;
          mem_addr_d      = req_addr[ptr_q*ADDR_WIDTH +: ADDR_WIDTH];
          mem_data_d      = req_data[ptr_q*LINE_WIDTH +: LINE_WIDTH];
          // A simultaneous read and write is treated as a write.
          mem_write_d     = req_write[ptr_q];
          mem_read_d      = ~req_write[ptr_q];
          bus_available_d = '0;
          busy_d          = 1'b1;
          cnt_d           = '0;
          state_d         = StIssue;
        end else if (cnt_q == CntW'(GRANT_WINDOW - 1)) begin
          ptr_d           = next_ptr(ptr_q);
          cnt_d           = '0;
          bus_available_d = onehot(next_ptr(ptr_q));
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StIssue: begin
        spurious_d = mem_resp_valid;
        state_d    = StWait;
      end
      StWait: begin
        if (resp_match) begin
          resp_valid_d[owner_q] = 1'b1;
          resp_addr_d           = mem_resp_addr;
          resp_data_d           = mem_resp_data;
          busy_d                = 1'b0;
          ptr_d                 = next_ptr(owner_q);
          cnt_d                 = '0;
          bus_available_d       = onehot(next_ptr(owner_q));
          state_d               = StOffer;
        end else begin
          spurious_d = mem_resp_valid;
        end
      end
      default: state_d = StOffer;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= StOffer;
      ptr_q           <= '0;
      owner_q         <= '0;
      cnt_q           <= '0;
      bus_available_q <= '0;
      resp_valid_q    <= '0;
      resp_addr_q     <= '0;
      resp_data_q     <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_addr_q      <= '0;
      mem_data_q      <= '0;
      busy_q          <= 1'b0;
      spurious_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      owner_q         <= owner_d;
      cnt_q           <= cnt_d;
      bus_available_q <= bus_available_d;
      resp_valid_q    <= resp_valid_d;
      resp_addr_q     <= resp_addr_d;
      resp_data_q     <= resp_data_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_q      <= mem_data_d;
      busy_q          <= busy_d;
      spurious_q      <= spurious_d;
    end
  end

  assign bus_available = bus_available_q;
  assign resp_valid    = resp_valid_q;
  assign resp_addr     = resp_addr_q;
  assign resp_data     = resp_data_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign busy          = busy_q;
  assign spurious      = spurious_q;

endmodule

// File: tb/tb_cpu_mem_bus_arbiter.sv
// Self-checking bench for cpu_mem_bus_arbiter: a transaction-level model predicts every
// output each cycle, and directed literal checks pin the model to known sequences.
module tb_cpu_mem_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int GW = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_read = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_data = '0;
  logic [N-1:0]    bus_available;
  logic [N-1:0]    resp_valid;
  logic [AW-1:0]   resp_addr;
  logic [LW-1:0]   resp_data;
  logic            mem_read;
  logic            mem_write;
  logic [AW-1:0]   mem_addr;
  logic [LW-1:0]   mem_data;
  logic            mem_resp_valid = 1'b0;
  logic [AW-1:0]   mem_resp_addr = '0;
  logic [LW-1:0]   mem_resp_data = '0;
  logic            busy;
  logic            spurious;

  cpu_mem_bus_arbiter #(
    .NUM_REQ     (N),
    .ADDR_WIDTH  (AW),
    .LINE_WIDTH  (LW),
    .GRANT_WINDOW(GW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_read      (req_read),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .bus_available (bus_available),
    .resp_valid    (resp_valid),
    .resp_addr     (resp_addr),
    .resp_data     (resp_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_addr (mem_resp_addr),
    .mem_resp_data (mem_resp_data),
    .busy          (busy),
    .spurious      (spurious)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // stage: 0 = bus being offered, 1 = request on the memory bus, 2 = awaiting response
  int           m_ptr, m_age, m_owner, m_stage;
  logic [N-1:0] e_bus, e_rv;
  logic [AW-1:0] e_raddr, e_maddr;
  logic [LW-1:0] e_rdata, e_mdata;
  logic         e_mr, e_mw, e_busy, e_spur;

  task automatic model_reset();
    m_ptr = 0; m_age = 0; m_owner = 0; m_stage = 0;
    e_bus = '0; e_rv = '0; e_raddr = '0; e_rdata = '0; e_mr = 0; e_mw = 0;
    e_maddr = '0; e_mdata = '0; e_busy = 0; e_spur = 0;
  endtask

  task automatic model_step();
    e_rv = '0; e_mr = 0; e_mw = 0; e_spur = 0;
    if (m_stage == 2) begin
      if (mem_resp_valid && mem_resp_addr == e_maddr) begin
        e_rv = '0; e_rv[m_owner] = 1'b1;
        e_raddr = mem_resp_addr; e_rdata = mem_resp_data;
        e_busy = 0;
        m_ptr = (m_owner + 1) % N; m_age = 0;
        e_bus = '0; e_bus[m_ptr] = 1'b1;
        m_stage = 0;
      end else begin
        e_spur = mem_resp_valid;
      end
    end else begin
      e_spur = mem_resp_valid;
      if (m_stage == 1) begin
        m_stage = 2;
      end else if (e_bus == '0) begin
        e_bus[m_ptr] = 1'b1;
      end else if (req_read[m_ptr] || req_write[m_ptr]) begin
        m_owner = m_ptr;
        e_maddr = req_addr[m_ptr*AW +: AW];
        e_mdata = req_data[m_ptr*LW +: LW];
        e_mw = req_write[m_ptr]; e_mr = !req_write[m_ptr];
        e_bus = '0; e_busy = 1; m_age = 0;
        m_stage = 1;
      end else begin
        m_age++;
        if (m_age == GW) begin
          m_ptr = (m_ptr + 1) % N; m_age = 0;
          e_bus = '0; e_bus[m_ptr] = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("bus_available", bus_available, e_bus);
      chk("resp_valid", resp_valid, e_rv);
      chk("resp_addr", resp_addr, e_raddr);
      chk("resp_data", resp_data, e_rdata);
      chk("mem_read", mem_read, e_mr);
      chk("mem_write", mem_write, e_mw);
      chk("mem_addr", mem_addr, e_maddr);
      chk("mem_data", mem_data, e_mdata);
      chk("busy", busy, e_busy);
      chk("spurious", spurious, e_spur);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_bus(input logic [N-1:0] target, input string name);
    int n = 0;
    while (bus_available !== target && n < 20) begin
      tick();
      n++;
    end
    chk(name, bus_available, target);
  endtask

  task automatic clear_inputs();
    req_read = '0; req_write = '0;
    mem_resp_valid = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, 7) * 16);
  endfunction

  localparam logic [LW-1:0] RdLine = 128'hFFEEDDCC_FFEEDDCC_FFEEDDCC_FFEEDDCC;

  initial begin
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Reset held for two cycles
    tick(); tick();
    chk("rst_bus", bus_available, 2'b00);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    tick();
    chk("first_offer", bus_available, 2'b01);
    chk("first_busy", busy, 1'b0);

    // Single read from cache 0
    req_read = 2'b01; req_addr[0 +: AW] = 32'h0;
    tick();
    clear_inputs();
    chk("rd_mem_read", mem_read, 1'b1);
    chk("rd_mem_addr", mem_addr, 32'h0);
    chk("rd_busy", busy, 1'b1);
    chk("rd_bus_off", bus_available, 2'b00);
    tick();
    chk("rd_pulse_end", mem_read, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_addr = 32'h0; mem_resp_data = RdLine;
    tick();
    clear_inputs();
    chk("rd_resp_valid", resp_valid, 2'b01);
    chk("rd_resp_data", resp_data, RdLine);
    chk("rd_next_offer", bus_available, 2'b10);
    tick();
    chk("rd_resp_once", resp_valid, 2'b00);

    // Window rotation with no requests
    wait_bus(2'b01, "rot_sync");
    for (int i = 0; i < 16; i++) begin
      chk("rotation", bus_available, ((i / 4) % 2 == 1) ? 2'b10 : 2'b01);
      tick();
    end

    // Cache 1 request while cache 0 is offered is ignored
    wait_bus(2'b01, "ign_sync");
    req_write = 2'b10; req_addr[AW +: AW] = 32'h10; req_data[LW +: LW] = 128'h11223344;
    tick();
    clear_inputs();
    chk("ign_no_write", mem_write, 1'b0);
    chk("ign_not_busy", busy, 1'b0);
    wait_bus(2'b10, "wr_offer");
    req_write = 2'b10;
    tick();
    clear_inputs();
    chk("wr_pulse", mem_write, 1'b1);
    chk("wr_data", mem_data, 128'h11223344);
    chk("wr_addr", mem_addr, 32'h10);
    tick();
    mem_resp_valid = 1'b1; mem_resp_addr = 32'h10;
    tick();
    clear_inputs();
    chk("wr_resp_valid", resp_valid, 2'b10);
    chk("wr_back_to_0", bus_available, 2'b01);

    // Spurious in OFFER, then mismatched response in WAIT
    mem_resp_valid = 1'b1; mem_resp_addr = 32'h55;
    tick();
    clear_inputs();
    chk("sp_offer", spurious, 1'b1);
    chk("sp_no_resp", resp_valid, 2'b00);
    req_read = 2'b01; req_addr[0 +: AW] = 32'h20;
    tick();
    clear_inputs();
    tick();
    mem_resp_valid = 1'b1; mem_resp_addr = 32'h30;
    tick();
    clear_inputs();
    chk("sp_mismatch", spurious, 1'b1);
    chk("sp_still_busy", busy, 1'b1);
    chk("sp_no_resp2", resp_valid, 2'b00);
    tick();
    mem_resp_valid = 1'b1; mem_resp_addr = 32'h20;
    tick();
    clear_inputs();
    chk("sp_match_resp", resp_valid, 2'b01);
    chk("sp_match_addr", resp_addr, 32'h20);
    chk("sp_match_idle", busy, 1'b0);

    // Reset while waiting for a response
    req_read = 2'b10; req_addr[AW +: AW] = 32'h40;
    tick();
    clear_inputs();
    tick();
    chk("mr_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("mr_busy_clr", busy, 1'b0);
    chk("mr_bus_clr", bus_available, 2'b00);
    tick();
    reset = 1'b1;
    tick();
    chk("mr_ptr0", bus_available, 2'b01);
    mem_resp_valid = 1'b1; mem_resp_addr = 32'h40;
    tick();
    clear_inputs();
    chk("mr_spurious", spurious, 1'b1);
    chk("mr_no_resp", resp_valid, 2'b00);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int r = 0; r < N; r++) begin
        req_read[r]  = ($urandom_range(0, 3) == 0);
        req_write[r] = ($urandom_range(0, 3) == 0);
        req_addr[r*AW +: AW] = rand_addr();
        req_data[r*LW +: LW] = {$urandom, $urandom, $urandom, $urandom};
      end
      mem_resp_valid = ($urandom_range(0, 5) == 0);
      mem_resp_addr  = (m_stage == 2 && $urandom_range(0, 3) != 0) ? e_maddr : rand_addr();
      mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 499) == 0) reset = 1'b0;
      tick();
      reset = 1'b1;
    end
    clear_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_bus_arbiter.md
Name: cpu_mem_bus_arbiter

Overview:
Shares the single memory bus between NUM_REQ cache ports (default 2: I-cache = 0, D-cache = 1). It offers mem_bus_available to one cache at a time in round-robin order, and captures the one-cycle read/write request of the cache it is offering to. It forwards that request to memory as a one-cycle pulse, holds the bus until memory responds, and routes the line response back only to the owning cache.

Parameters:
NUM_REQ, 2, number of cache requesters (>=2)
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 128, cache line width on the bus
GRANT_WINDOW, 4, cycles a requester is offered the bus before the pointer advances (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_read  in  NUM_REQ  per-requester read pulse
req_write  in  NUM_REQ  per-requester write pulse
req_addr  in  NUM_REQ*ADDR_WIDTH  flat per-requester line address; slot i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  NUM_REQ*LINE_WIDTH  flat per-requester write line
bus_available  out  NUM_REQ  one-hot offer (mem_bus_available to cache i)
resp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
resp_addr  out  ADDR_WIDTH  response address (shared)
resp_data  out  LINE_WIDTH  response line (shared)
mem_read  out  1  one-cycle read request to memory
mem_write  out  1  one-cycle write request to memory
mem_addr  out  ADDR_WIDTH  latched request address
mem_data  out  LINE_WIDTH  latched write line
mem_resp_valid  in  1  memory response strobe (reads and write acks)
mem_resp_addr  in  ADDR_WIDTH  memory response address
mem_resp_data  in  LINE_WIDTH  memory response line
busy  out  1  high from request capture until response forwarded
spurious  out  1  one-cycle pulse on each dropped memory response

Behaviour:
- All outputs are registered.
- Reset (reset=0, async): state=OFFER, ptr=0, window count=0. All outputs are 0 except bus_available, which is 0 while reset is asserted.
- First cycle after reset release: bus_available[0]=1.
- State OFFER: bus_available = onehot(ptr).
  - Capture condition: bus_available[ptr]=1 and (req_read[ptr] | req_write[ptr]) sampled at a clock edge.
  - On capture: latch addr, data and op; record owner=ptr; next state ISSUE; bus_available=0 and busy=1 from the next cycle.
  - Read and write both high: treated as a write.
  - Requests from non-offered requesters are ignored and not queued.
  - No request: count increments each cycle.
  - When count reaches GRANT_WINDOW-1 without capture: ptr = (ptr+1) mod NUM_REQ, count=0. The offer moves to the next requester on the next cycle.
- State ISSUE (exactly 1 cycle): mem_read or mem_write = 1; mem_addr/mem_data hold the latched values. Next state WAIT.
  - Capture at edge N gives the mem pulse in cycle N+1.
- State WAIT:
  - mem_read=mem_write=0; mem_addr/mem_data hold their values.
  - On mem_resp_valid with mem_resp_addr == latched addr:
    - Next cycle: resp_valid[owner]=1 for one cycle, resp_addr/resp_data = captured response, busy=0.
    - ptr = (owner+1) mod NUM_REQ, count=0, state OFFER.
    - bus_available for the new ptr rises in that same cycle.
  - On mem_resp_valid with an address mismatch: response dropped, spurious=1 for one cycle, remain in WAIT.
- mem_resp_valid in OFFER or ISSUE: dropped, spurious pulse, no state change.
- No timeout in WAIT: the bus is held until a matching response arrives.
- resp_data/resp_addr hold the last response between strobes.
- Reset asserted mid-transaction: outstanding transaction discarded, no resp_valid issued, ptr returns to 0.
- Fairness:
  - Each completed transaction passes the pointer to the next requester.
  - Each requester is offered the bus within (NUM_REQ-1)*GRANT_WINDOW cycles plus one outstanding transaction.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release. -> All outputs 0 during reset; bus_available=2'b01 in the first cycle after release; busy=0.
- Single read: cache 0 pulses req_read with addr 'h0 while offered. -> mem_read=1 for exactly the next cycle, mem_addr='h0, busy=1. Memory returns valid, addr 'h0, data 'hFFEEDDCC_FFEEDDCC_FFEEDDCC_FFEEDDCC. -> Next cycle resp_valid=2'b01 with that data; bus_available=2'b10.
- Window rotation: no requests, GRANT_WINDOW=4. -> bus_available alternates 2'b01 for 4 cycles, then 2'b10 for 4 cycles, repeating.
- Ignored requester: cache 1 pulses req_write while bus_available=2'b01. -> No mem_write. When offered, cache 1 writes addr 'h10, data 'h11223344. -> mem_write pulse with mem_data='h11223344. After the ack, resp_valid=2'b10 and the offer returns to 2'b01.
- Spurious and mismatched responses: mem_resp_valid while in OFFER -> spurious pulse, no resp_valid. In WAIT for addr 'h20, a response arrives with addr 'h30. -> spurious pulse, stays busy. A later response with addr 'h20 completes the transaction.
- Reset mid-WAIT: assert reset while busy=1. -> Outputs clear immediately; a later mem_resp_valid after release produces a spurious pulse and no resp_valid.
